// File: rtl/dmi_req_arbiter_if.sv
// Bundle of the transport-side and DM-side handshake signals around the DMI arbiter.
// master: the arbiter itself; slave: the transports plus the debug module core.
interface dmi_req_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0]             req_ready;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0][1:0]        req_op;
  logic [NREQ-1:0]             rsp_valid;
  logic [NREQ-1:0]             rsp_ready;
  logic [DATA_W-1:0]           rsp_data;
  logic [1:0]                  rsp_resp;

  logic                        dmi_req_valid;
  logic                        dmi_req_ready;
  logic [ADDR_W-1:0]           dmi_addr;
  logic [DATA_W-1:0]           dmi_wdata;
  logic [1:0]                  dmi_op;
  logic                        dmi_rsp_valid;
  logic                        dmi_rsp_ready;
  logic [DATA_W-1:0]           dmi_rdata;
  logic [1:0]                  dmi_resp;

  modport master (
    input  req_valid, req_addr, req_data, req_op, rsp_ready,
           dmi_req_ready, dmi_rsp_valid, dmi_rdata, dmi_resp,
    output req_ready, rsp_valid, rsp_data, rsp_resp,
           dmi_req_valid, dmi_addr, dmi_wdata, dmi_op, dmi_rsp_ready
  );

  modport slave (
    output req_valid, req_addr, req_data, req_op, rsp_ready,
           dmi_req_ready, dmi_rsp_valid, dmi_rdata, dmi_resp,
    input  req_ready, rsp_valid, rsp_data, rsp_resp,
           dmi_req_valid, dmi_addr, dmi_wdata, dmi_op, dmi_rsp_ready
  );
endinterface

// File: rtl/dmi_req_arbiter.sv
// Round-robin share of the single dmi_main request/response port between NREQ transports,
// one transaction in flight, with a response timeout and a drain window for late replies.

module dmi_req_arbiter_lane (
  input  logic idle_i,
  input  logic win_i,
  input  logic deliver_i,
  input  logic own_i,
  output logic req_ready_o,
  output logic rsp_valid_o
);
  assign req_ready_o = idle_i & win_i;
  assign rsp_valid_o = deliver_i & own_i;
endmodule

module dmi_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  dmi_req_arbiter_if.master bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_DELIVER = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  localparam logic [1:0] RESP_FAILED = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [1:0]        op;
  } req_t;

  logic [2:0]        state_q, state_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [PW-1:0]     gnt_q, gnt_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              to_q, to_d;
  req_t              lat_q, lat_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;

  logic [PW-1:0]     win;
  logic              win_vld;
  logic              cnt_last;
  logic [PW-1:0]     gnt_nxt;

  // Scan from rr_q upward; iterating from the far end lets the nearest valid requester win.
  always_comb begin
    int j;
    logic [PW-1:0] jw;
    win     = '0;
    win_vld = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j  = (int'(rr_q) + k) % NREQ;
      jw = PW'(j);
      if (bus.req_valid[jw]) begin
        win     = jw;
        win_vld = 1'b1;
      end
    end
  end

  assign cnt_last = (cnt_q == CW'(TIMEOUT - 1));
  assign gnt_nxt  = (gnt_q == PW'(NREQ - 1)) ? '0 : gnt_q + PW'(1);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          lat_d   = '{addr: bus.req_addr[win], data: bus.req_data[win], op: bus.req_op[win]};
          gnt_d   = win;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.dmi_req_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response on the last counted cycle still beats the timeout.
        if (bus.dmi_rsp_valid) begin
          rdata_d = bus.dmi_rdata;
          resp_d  = bus.dmi_resp;
          to_d    = 1'b0;
          state_d = S_DELIVER;
        end else if (cnt_last) begin
          rdata_d = '0;
          resp_d  = RESP_FAILED;
          to_d    = 1'b1;
          state_d = S_DELIVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DELIVER: begin
        if (bus.rsp_ready[gnt_q]) begin
          rr_d    = gnt_nxt;
          cnt_d   = '0;
          state_d = to_q ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        // Swallow a reply the DM may still send for the timed-out request.
        if (bus.dmi_rsp_valid || cnt_last) begin
          to_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      lat_q   <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      lat_q   <= lat_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.dmi_req_valid = (state_q == S_ISSUE);
  assign bus.dmi_rsp_ready = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign bus.dmi_addr      = lat_q.addr;
  assign bus.dmi_wdata     = lat_q.data;
  assign bus.dmi_op        = lat_q.op;
  assign bus.rsp_data      = rdata_q;
  assign bus.rsp_resp      = resp_q;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    dmi_req_arbiter_lane u_lane (
      .idle_i      (state_q == S_IDLE),
      .win_i       (win_vld && (win == PW'(i))),
      .deliver_i   (state_q == S_DELIVER),
      .own_i       (gnt_q == PW'(i)),
      .req_ready_o (bus.req_ready[i]),
      .rsp_valid_o (bus.rsp_valid[i])
    );
  end
endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Directed bench for dmi_req_arbiter: transaction-level model checked every cycle,
// plus literal expectations for the single read, contention, backpressure, timeout and reset cases.
module tb_dmi_req_arbiter;
  localparam int NREQ = 2, ADDR_W = 7, DATA_W = 32, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmi_req_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmi_req_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DM behaviour knobs, set by the directed sequence.
  int dm_rdy_wait = 0;   // ISSUE cycles with dmi_req_ready low before accepting
  int dm_rsp_lat  = 0;   // cycles after accept before replying; negative = silent
  int dm_late     = 0;   // when silent: late reply this many cycles after accept (0 = never)
  logic [DATA_W-1:0] dm_rdata = '0;
  logic [1:0]        dm_resp  = '0;

  initial begin : dm
    bit a, r, pend;
    int age, rcnt;
    bus.dmi_req_ready = 1'b0;
    bus.dmi_rsp_valid = 1'b0;
    bus.dmi_rdata     = '0;
    bus.dmi_resp      = '0;
    pend = 0; age = 0; rcnt = 0;
    forever begin
      @(negedge clk);
      a = bus.dmi_req_valid && bus.dmi_req_ready;
      r = bus.dmi_rsp_valid && bus.dmi_rsp_ready;
      @(posedge clk); #1;
      if (!rst_n) begin
        bus.dmi_req_ready = 1'b0;
        bus.dmi_rsp_valid = 1'b0;
        pend = 0; age = 0; rcnt = 0;
      end else begin
        if (r) bus.dmi_rsp_valid = 1'b0;
        if (a) begin
          bus.dmi_req_ready = 1'b0;
          pend = 1; age = 0; rcnt = 0;
        end else if (pend) age++;
        if (bus.dmi_req_valid && !bus.dmi_req_ready) begin
          if (rcnt >= dm_rdy_wait) bus.dmi_req_ready = 1'b1;
          else rcnt++;
        end
        if (pend && ((dm_rsp_lat >= 0 && age == dm_rsp_lat) ||
                     (dm_rsp_lat < 0 && dm_late > 0 && age == dm_late))) begin
          bus.dmi_rsp_valid = 1'b1;
          bus.dmi_rdata     = dm_rdata;
          bus.dmi_resp      = dm_resp;
          pend = 0;
        end
      end
    end
  end

  // Transaction tracker: who owns the port, whether the DM took the request,
  // how long it has waited, and what the requester must be shown.
  int m_ptr = 0, m_owner = -1, m_waited = 0, m_dcnt = 0;
  bit m_sent = 0, m_have = 0, m_to = 0, m_drain = 0;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic [1:0]        m_op, m_resp;

  function automatic int pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  always @(negedge clk) begin : model
    logic [NREQ-1:0] e_rdy, e_rv;
    int w;
    if (!rst_n) begin
      chk("rst_handshakes", {bus.req_ready, bus.rsp_valid, bus.dmi_req_valid, bus.dmi_rsp_ready}, '0);
      chk("rst_dmi_fields", {bus.dmi_addr, bus.dmi_wdata, bus.dmi_op}, '0);
      chk("rst_rsp_fields", {bus.rsp_data, bus.rsp_resp}, '0);
      m_ptr = 0; m_owner = -1; m_waited = 0; m_dcnt = 0;
      m_sent = 0; m_have = 0; m_to = 0; m_drain = 0;
    end else begin
      w = (m_owner < 0 && !m_drain) ? pick(m_ptr, bus.req_valid) : -1;
      e_rdy = '0;
      if (w >= 0) e_rdy[w] = 1'b1;
      e_rv = '0;
      if (m_have) e_rv[m_owner] = 1'b1;
      chk("req_ready", bus.req_ready, e_rdy);
      chk("dmi_req_valid", bus.dmi_req_valid, (m_owner >= 0 && !m_sent));
      chk("dmi_rsp_ready", bus.dmi_rsp_ready, ((m_owner >= 0 && m_sent && !m_have) || m_drain));
      chk("rsp_valid", bus.rsp_valid, e_rv);
      if (m_owner >= 0 && !m_sent) begin
        chk("dmi_addr", bus.dmi_addr, m_addr);
        chk("dmi_wdata", bus.dmi_wdata, m_wdata);
        chk("dmi_op", bus.dmi_op, m_op);
      end
      if (m_have) begin
        chk("rsp_data", bus.rsp_data, m_rdata);
        chk("rsp_resp", bus.rsp_resp, m_resp);
      end
      // advance to what the next edge will do
      if (w >= 0) begin
        m_owner = w; m_sent = 0; m_have = 0;
        m_addr = bus.req_addr[w]; m_wdata = bus.req_data[w]; m_op = bus.req_op[w];
      end else if (m_owner >= 0 && !m_sent) begin
        if (bus.dmi_req_ready) begin m_sent = 1; m_waited = 0; end
      end else if (m_owner >= 0 && !m_have) begin
        if (bus.dmi_rsp_valid) begin
          m_have = 1; m_to = 0; m_rdata = bus.dmi_rdata; m_resp = bus.dmi_resp;
        end else if (m_waited == TIMEOUT - 1) begin
          m_have = 1; m_to = 1; m_rdata = '0; m_resp = 2'd2;
        end else m_waited++;
      end else if (m_have) begin
        if (bus.rsp_ready[m_owner]) begin
          m_ptr = (m_owner + 1) % NREQ;
          m_owner = -1; m_have = 0;
          if (m_to) begin m_drain = 1; m_dcnt = 0; m_to = 0; end
        end
      end else if (m_drain) begin
        if (bus.dmi_rsp_valid || m_dcnt == TIMEOUT - 1) m_drain = 0;
        else m_dcnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                      input logic [1:0] op);
    bit got;
    got = 0;
    bus.req_addr[i] = a; bus.req_data[i] = d; bus.req_op[i] = op; bus.req_valid[i] = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (bus.req_ready[i]) got = 1;
    end
    if (!got) chk("send_bound", bus.req_ready[i], 1);
    tick();
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, output int wcnt);
    bit got;
    got = 0; wcnt = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (bus.rsp_valid[i]) got = 1;
      else if (bus.dmi_rsp_ready) wcnt++;
    end
    if (!got) chk("rsp_wait_bound", bus.rsp_valid[i], 1);
  endtask

  initial begin : watchdog
    #300000;
    errors++; checks++;
    $display("FAIL watchdog: bench did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : seq
    int wc, g, idx, nv;
    bit found;
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_op = '0;
    bus.rsp_ready = '1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_dmi_addr", bus.dmi_addr, 0);
    chk("reset_rsp_resp", bus.rsp_resp, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    tick();

    // single read, minimum occupancy
    dm_rdata = 32'hDEADBEEF; dm_resp = 2'd0;
    bus.req_addr[0] = 7'h11; bus.req_op[0] = 2'd1; bus.req_data[0] = 32'h0; bus.req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t1_c0_req_ready", bus.req_ready, 2'b01);
    tick(); bus.req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_c1_dmi_req_valid", bus.dmi_req_valid, 1);
    chk("t1_c1_dmi_addr", bus.dmi_addr, 7'h11);
    chk("t1_c1_dmi_op", bus.dmi_op, 1);
    tick(); @(negedge clk);
    chk("t1_c2_dmi_rsp_ready", bus.dmi_rsp_ready, 1);
    tick(); @(negedge clk);
    chk("t1_c3_rsp_valid", bus.rsp_valid, 2'b01);
    chk("t1_c3_rsp_data", bus.rsp_data, 32'hDEADBEEF);
    chk("t1_c3_rsp_resp", bus.rsp_resp, 0);
    tick();
    bus.req_addr[1] = 7'h22; bus.req_op[1] = 2'd0; bus.req_data[1] = 32'h22; bus.req_valid[1] = 1'b1;
    @(negedge clk);
    chk("t1_c4_idle_accept", bus.req_ready, 2'b10);
    tick(); bus.req_valid[1] = 1'b0;
    wait_rsp(1, wc);
    tick();

    // contention: both valid with writes
    dm_rdata = 32'h0000_00C0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_addr[i] = ADDR_W'(7'h30 + i); bus.req_data[i] = 32'hA000_0000 + i;
      bus.req_op[i] = 2'd2; bus.req_valid[i] = 1'b1;
    end
    for (g = 0; g < 4; g++) begin
      found = 0;
      for (int n = 0; n < 50 && !found; n++) begin
        @(negedge clk);
        if (|bus.req_ready) found = 1;
      end
      idx = bus.req_ready[1] ? 1 : 0;
      chk("t2_grant_seen", |bus.req_ready, 1);
      chk("t2_grant_order", idx, exp_order[g]);
    end
    tick();
    bus.req_valid = '0;
    repeat (8) tick();

    // backpressure on both sides
    dm_rdy_wait = 5; dm_rdata = 32'h5555AAAA; dm_resp = 2'd3;
    bus.rsp_ready[1] = 1'b0;
    send(1, 7'h5A, 32'h0, 2'd1);
    nv = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.dmi_req_valid) begin
        nv++;
        chk("t3_addr_stable", bus.dmi_addr, 7'h5A);
      end
    end
    chk("t3_issue_cycles", nv, 6);
    wait_rsp(1, wc);
    for (int n = 0; n < 3; n++) begin
      if (n > 0) begin tick(); @(negedge clk); end
      chk("t3_rsp_valid_hold", bus.rsp_valid, 2'b10);
      chk("t3_rsp_data_hold", bus.rsp_data, 32'h5555AAAA);
      chk("t3_rsp_resp_hold", bus.rsp_resp, 3);
    end
    tick(); bus.rsp_ready[1] = 1'b1;
    dm_rdy_wait = 0; dm_resp = 2'd0;
    repeat (3) tick();

    // timeout with a late reply dropped in the drain window
    dm_rsp_lat = -1; dm_late = TIMEOUT + 10;
    send(0, 7'h44, 32'h0, 2'd1);
    wait_rsp(0, wc);
    chk("t4_wait_cycles", wc, TIMEOUT);
    chk("t4_rsp_resp", bus.rsp_resp, 2);
    chk("t4_rsp_data", bus.rsp_data, 0);
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (bus.dmi_rsp_valid) found = 1;
    end
    chk("t4_late_seen", bus.dmi_rsp_valid, 1);
    chk("t4_late_drain_ready", bus.dmi_rsp_ready, 1);
    chk("t4_late_no_rsp", bus.rsp_valid, 0);
    tick(); @(negedge clk);
    chk("t4_drain_exit", bus.dmi_rsp_ready, 0);
    dm_rsp_lat = 0; dm_late = 0; dm_rdata = 32'h12345678;
    tick();
    send(1, 7'h45, 32'h0, 2'd1);
    wait_rsp(1, wc);
    chk("t4_next_data", bus.rsp_data, 32'h12345678);
    chk("t4_next_resp", bus.rsp_resp, 0);
    repeat (2) tick();

    // response exactly on the last counted cycle
    dm_rsp_lat = TIMEOUT - 1; dm_rdata = 32'hCAFEF00D;
    send(0, 7'h50, 32'h0, 2'd1);
    wait_rsp(0, wc);
    chk("t5_wait_cycles", wc, TIMEOUT);
    chk("t5_rsp_data", bus.rsp_data, 32'hCAFEF00D);
    chk("t5_rsp_resp", bus.rsp_resp, 0);
    tick(); @(negedge clk);
    chk("t5_no_drain", bus.dmi_rsp_ready, 0);
    tick();

    // async reset in the middle of WAIT
    dm_rsp_lat = -1; dm_late = 0;
    send(1, 7'h66, 32'h0, 2'd1);
    repeat (5) tick();
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("t6_async_handshakes", {bus.req_ready, bus.rsp_valid, bus.dmi_req_valid, bus.dmi_rsp_ready}, 0);
    chk("t6_async_dmi_addr", bus.dmi_addr, 0);
    chk("t6_async_dmi_op", bus.dmi_op, 0);
    chk("t6_async_rsp_data", bus.rsp_data, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;
    dm_rsp_lat = 0; dm_rdata = 32'h00000777;
    tick();
    bus.req_addr[0] = 7'h70; bus.req_op[0] = 2'd1; bus.req_valid[0] = 1'b1;
    bus.req_addr[1] = 7'h71; bus.req_op[1] = 2'd1; bus.req_valid[1] = 1'b1;
    @(negedge clk);
    chk("t6_rr_reset", bus.req_ready, 2'b01);
    tick(); bus.req_valid[0] = 1'b0;
    send(1, 7'h71, 32'h0, 2'd1);
    wait_rsp(1, wc);
    chk("t6_req1_data", bus.rsp_data, 32'h00000777);
    chk("t6_req1_resp", bus.rsp_resp, 0);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmi_req_arbiter.md
Name: dmi_req_arbiter

Overview:
Shares the single DMI request/response port of the debug module core (dmi_main) between NREQ transport requesters, e.g. JTAG DTM and a secondary debug bridge.
- Round-robin arbitration; one outstanding DMI transaction at a time.
- Holds the grant until the response is delivered.
- Times out DM responses that never arrive, returning a failed status.
Sits between the transports and dmi_main inside the debug subsystem.

Parameters:
NREQ, 2, number of requesters (2..8)
ADDR_W, 7, DMI address width
DATA_W, 32, DMI data width (matches WID)
TIMEOUT, 64, max cycles waiting for a DM response (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester request accept
req_addr  in  NREQ*ADDR_W  flattened addresses; requester i at [i*ADDR_W +: ADDR_W]
req_data  in  NREQ*DATA_W  flattened write data
req_op  in  NREQ*2  flattened ops (0 nop, 1 read, 2 write)
rsp_valid  out  NREQ  per-requester response valid
rsp_ready  in  NREQ  per-requester response accept
rsp_data  out  DATA_W  response data, shared; qualified by rsp_valid
rsp_resp  out  2  response status (0 ok, 2 failed, 3 busy)
dmi_req_valid  out  1  request to DM
dmi_req_ready  in  1  DM accepts request
dmi_addr  out  ADDR_W  latched address
dmi_wdata  out  DATA_W  latched write data
dmi_op  out  2  latched op
dmi_rsp_valid  in  1  DM response valid
dmi_rsp_ready  out  1  arbiter accepts DM response
dmi_rdata  in  DATA_W  DM read data
dmi_resp  in  2  DM status

Behaviour:
- Reset (reset=0, async): state IDLE; rr_ptr=0; gnt=0; timeout counter=0; to_flag=0; all valid/ready outputs 0; dmi_addr/dmi_wdata/dmi_op/rsp_data/rsp_resp=0. Reset mid-transaction drops it silently.
- FSM states: IDLE, ISSUE, WAIT, DELIVER, DRAIN.
- IDLE:
  - Winner is the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner]=1 combinationally (single-cycle accept). All other req_ready bits stay 0.
  - Latch addr/data/op and gnt=winner; go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - dmi_req_valid=1; dmi_addr/dmi_wdata/dmi_op stable from latches.
  - On dmi_req_ready: go to WAIT, counter=0.
  - No timeout here; valid is never withdrawn.
- WAIT:
  - dmi_rsp_ready=1; counter increments each cycle.
  - On dmi_rsp_valid: capture dmi_rdata/dmi_resp into rsp_data/rsp_resp; go to DELIVER.
  - Else if counter==TIMEOUT-1: rsp_data=0, rsp_resp=2, to_flag=1; go to DELIVER.
  - Response and timeout in the same cycle: the response wins, to_flag stays 0.
- DELIVER:
  - rsp_valid[gnt]=1; data/resp held until rsp_ready[gnt].
  - On that handshake: rr_ptr=(gnt+1) mod NREQ; go to DRAIN if to_flag, else IDLE.
- DRAIN:
  - dmi_rsp_ready=1; counter restarts at 0.
  - A late dmi_rsp_valid is discarded; clear to_flag, go to IDLE.
  - If none arrives after TIMEOUT cycles: clear to_flag, go to IDLE.
- All req_ready are 0 outside IDLE. Requests arriving while busy wait; no queueing.
- Minimum occupancy is 4 cycles: accept (IDLE), issue with ready, response, deliver with ready.
- Nop ops are forwarded like any other op.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.

Test Plan:
- Single read: req0 valid addr=0x11 op=1; DM ready immediately, responds rdata=0xDEADBEEF resp=0 the next cycle -> req_ready[0] at cycle 0; rsp_valid[0] with 0xDEADBEEF, resp 0 at cycle 3; back in IDLE at cycle 4.
- Contention: req0 and req1 both valid continuously with writes -> grant order 0,1,0,1; dmi_wdata matches the granted requester each time; no grant while DELIVER is pending.
- Backpressure: dmi_req_ready low 5 cycles, then rsp_ready[1] low 3 cycles -> dmi_req_valid and dmi_addr stable for all 5 cycles; rsp_valid[1], rsp_data, rsp_resp stable until the handshake.
- Timeout: DM silent after accepting -> rsp_resp=2, rsp_data=0 at WAIT cycle TIMEOUT (64); DM late response 10 cycles later is dropped (DRAIN), and the next request completes normally.
- Edge: response arrives exactly on the TIMEOUT-1 cycle -> real data delivered, no DRAIN entered.
- Async reset asserted mid-WAIT, negated after 3 cycles -> all outputs 0 immediately; rr_ptr=0; a new req1 is granted normally.
